// File: rtl/lcd_pkg.sv
// Shared constants and state encodings for the 1602 LCD field refresh controller.
package lcd_pkg;

  localparam logic [7:0] CLEAR      = 8'h01;
  localparam logic [7:0] ENTRY      = 8'h06;
  localparam logic [7:0] DISP_ON    = 8'h0C;
  localparam logic [7:0] FUNC_8B2L  = 8'h38;
  localparam logic [7:0] SET_DDRAM  = 8'h80;
  localparam logic [7:0] ASCII_ZERO = 8'h30;

  typedef enum logic [2:0] {PWR_WAIT, INIT, IDLE, HOST, FADDR, FCHAR} top_state_e;
  typedef enum logic [1:0] {SETUP, STROBE, HOLD} phase_e;

endpackage

// File: rtl/lcd_field_refresh_ctrl_strobe.sv
// One LCD bus write: SETUP / STROBE / HOLD phases of TICK_CYCLES clocks each,
// with rs and data latched at start and held until the next transaction.
module lcd_bus_strobe
  import lcd_pkg::*;
#(
  parameter int TICK_CYCLES = 800000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       rs_i,
  input  logic [7:0] data_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       rs_o,
  output logic       en_o,
  output logic [7:0] data_o
);

  localparam int CNT_W = $clog2(TICK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

  logic             busy_q, busy_d;
  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             phase_end, done;

  assign phase_end = (cnt_q == CNT_LAST);
  assign done      = busy_q && (phase_q == HOLD) && phase_end;

  // A start is accepted in the final HOLD cycle too, so bytes go back to back.
  always_comb begin
    busy_d  = busy_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    rs_d    = rs_q;
    data_d  = data_q;
    if (start_i && (!busy_q || done)) begin
      busy_d  = 1'b1;
      phase_d = SETUP;
      cnt_d   = '0;
      rs_d    = rs_i;
      data_d  = data_i;
    end else if (busy_q) begin
      if (phase_end) begin
        cnt_d = '0;
        unique case (phase_q)
          SETUP:   phase_d = STROBE;
          STROBE:  phase_d = HOLD;
          default: begin
            phase_d = SETUP;
            busy_d  = 1'b0;
          end
        endcase
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= 1'b0;
      phase_q <= SETUP;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      busy_q  <= busy_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done;
  assign rs_o   = rs_q;
  assign en_o   = busy_q && (phase_q == STROBE);
  assign data_o = data_q;

endmodule

// File: rtl/lcd_field_refresh_ctrl.sv
// 1602 LCD controller: power-on wait, init commands, then repaints only changed
// single-digit fields; a req/ack port lets other painters share the bus.
module lcd_field_refresh_ctrl
  import lcd_pkg::*;
#(
  parameter int                        NUM_FIELDS    = 3,
  parameter int                        VALUE_W       = 4,
  parameter logic [NUM_FIELDS*8-1:0]   FIELD_ADDR    = {8'hCB, 8'h8F, 8'h89},
  parameter int                        TICK_CYCLES   = 800000,
  parameter int                        POWERON_TICKS = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_FIELDS*VALUE_W-1:0] values,
  input  logic                          host_req,
  input  logic                          host_rs,
  input  logic [7:0]                    host_data,
  output logic                          host_ack,
  output logic                          init_done,
  output logic                          rs,
  output logic                          rw,
  output logic                          enable,
  output logic [7:0]                    data
);

  localparam int IDX_W    = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int WAIT_CYC = POWERON_TICKS * TICK_CYCLES;
  localparam int WAIT_W   = $clog2(WAIT_CYC + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FIELDS - 1);

  function automatic logic [7:0] digit_char(input logic [VALUE_W-1:0] v);
    if (int'(v) > 9) return ASCII_ZERO + 8'd9;
    return ASCII_ZERO + 8'(v);
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return FUNC_8B2L;
      2'd1:    return ENTRY;
      2'd2:    return DISP_ON;
      default: return CLEAR;
    endcase
  endfunction

  top_state_e                   state_q, state_d;
  logic [WAIT_W-1:0]            wait_q, wait_d;
  logic [1:0]                   init_idx_q, init_idx_d;
  logic [VALUE_W-1:0]           cap_q, cap_d;
  logic [IDX_W-1:0]             cur_q, cur_d, last_q, last_d;
  logic [NUM_FIELDS*VALUE_W-1:0] shadow_q, shadow_d;
  logic [NUM_FIELDS-1:0]        force_q, force_d;
  logic                         init_done_q, init_done_d;

  logic [NUM_FIELDS-1:0] dirty;
  logic                  found;
  logic [IDX_W-1:0]      pick_idx;
  int                    pick_scan;
  logic [VALUE_W-1:0]    pick_val;
  logic [7:0]            pick_addr;
  logic                  bus_start, bus_rs, bus_busy, bus_done, ack_c;
  logic [7:0]            bus_byte;

  always_comb begin
    dirty = '0;
    for (int i = 0; i < NUM_FIELDS; i++)
      dirty[i] = force_q[i] ||
                 (values[i*VALUE_W +: VALUE_W] != shadow_q[i*VALUE_W +: VALUE_W]);
  end

  // Round-robin scan starts just after the last field that was painted.
  always_comb begin
    found     = 1'b0;
    pick_idx  = '0;
    pick_scan = 0;
    for (int k = 1; k <= NUM_FIELDS; k++) begin
      pick_scan = int'(last_q) + k;
      if (pick_scan >= NUM_FIELDS) pick_scan = pick_scan - NUM_FIELDS;
      if (!found && dirty[IDX_W'(pick_scan)]) begin
        found    = 1'b1;
        pick_idx = IDX_W'(pick_scan);
      end
    end
  end

  assign pick_val  = values[int'(pick_idx)*VALUE_W +: VALUE_W];
  assign pick_addr = FIELD_ADDR[int'(pick_idx)*8 +: 8];

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    init_idx_d  = init_idx_q;
    cap_d       = cap_q;
    cur_d       = cur_q;
    last_d      = last_q;
    shadow_d    = shadow_q;
    force_d     = force_q;
    init_done_d = init_done_q;
    bus_start   = 1'b0;
    bus_rs      = 1'b0;
    bus_byte    = 8'h00;
    ack_c       = 1'b0;
    unique case (state_q)
      PWR_WAIT: begin
        if (wait_q == WAIT_W'(WAIT_CYC - 1)) begin
          bus_start  = 1'b1;
          bus_byte   = init_cmd(2'd0);
          init_idx_d = 2'd0;
          state_d    = INIT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      INIT: begin
        if (bus_done) begin
          if (init_idx_q == 2'd3) begin
            init_done_d = 1'b1;
            state_d     = IDLE;
          end else begin
            init_idx_d = init_idx_q + 2'd1;
            bus_start  = 1'b1;
            bus_byte   = init_cmd(init_idx_q + 2'd1);
          end
        end
      end
      IDLE: begin
        if (!bus_busy && host_req) begin
          bus_start = 1'b1;
          bus_rs    = host_rs;
          bus_byte  = host_data;
          state_d   = HOST;
        end else if (!bus_busy && found) begin
          cur_d     = pick_idx;
          cap_d     = pick_val;
          bus_start = 1'b1;
          bus_byte  = SET_DDRAM | pick_addr;
          state_d   = FADDR;
        end
      end
      HOST: begin
        if (bus_done) begin
          ack_c   = 1'b1;
          state_d = IDLE;
        end
      end
      FADDR: begin
        if (bus_done) begin
          bus_start = 1'b1;
          bus_rs    = 1'b1;
          bus_byte  = digit_char(cap_q);
          state_d   = FCHAR;
        end
      end
      default: begin
        if (bus_done) begin
          shadow_d[int'(cur_q)*VALUE_W +: VALUE_W] = cap_q;
          force_d[cur_q] = 1'b0;
          last_d         = cur_q;
          state_d        = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= PWR_WAIT;
      wait_q      <= '0;
      init_idx_q  <= 2'd0;
      cap_q       <= '0;
      cur_q       <= '0;
      last_q      <= LAST_IDX;
      shadow_q    <= '0;
      force_q     <= '1;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      init_idx_q  <= init_idx_d;
      cap_q       <= cap_d;
      cur_q       <= cur_d;
      last_q      <= last_d;
      shadow_q    <= shadow_d;
      force_q     <= force_d;
      init_done_q <= init_done_d;
    end
  end

  lcd_bus_strobe #(.TICK_CYCLES(TICK_CYCLES)) u_strobe (
    .clk    (clk),
    .rst    (reset),
    .start_i(bus_start),
    .rs_i   (bus_rs),
    .data_i (bus_byte),
    .busy_o (bus_busy),
    .done_o (bus_done),
    .rs_o   (rs),
    .en_o   (enable),
    .data_o (data)
  );

  assign host_ack  = ack_c;
  assign init_done = init_done_q;
  assign rw        = 1'b0;

endmodule
